// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 keyboard receiver: bus addresses, KBSR bit positions, rx FSM states.
package lc3_pkg;

    localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;

    localparam int KBSR_READY = 15;
    localparam int KBSR_IE    = 14;
    localparam int KBSR_FERR  = 13;
    localparam int KBSR_OVR   = 12;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic [15:0] kbsr_word(input logic ready, input logic ie,
                                              input logic ferr, input logic ovr);
        logic [15:0] w;
        w             = '0;
        w[KBSR_READY] = ready;
        w[KBSR_IE]    = ie;
        w[KBSR_FERR]  = ferr;
        w[KBSR_OVR]   = ovr;
        return w;
    endfunction

endpackage

// File: rtl/lc3_kbd_rx_if.sv
// LC-3 memory-mapped bus as seen by the keyboard device: address, strobes, write data and registered read data.
interface lc3_kbd_rx_if;
    logic [15:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;

    modport master (output addr, output rd_en, output wr_en, output wr_data, input rd_data);
    modport slave  (input addr, input rd_en, input wr_en, input wr_data, output rd_data);
endinterface

// File: rtl/lc3_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle byte/frame-error pulses.
module lc3_uart_rx
    import lc3_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync_d;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    logic w_fall;
    logic w_tick;

    assign w_fall = r_sync_d & ~r_sync2;
    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync_d     <= 1'b1;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            o_byte_valid <= 1'b0;
            o_byte       <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            r_sync_d     <= r_sync2;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            if (!w_tick) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= HALF;
                    end
                end
                START: begin
                    // A start bit that has gone high again by mid-bit was only a glitch
                    if (w_tick) begin
                        if (!r_sync2) begin
                            r_state <= DATA;
                            r_cnt   <= FULL_M1;
                            r_bit   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= FULL_M1;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        if (r_sync2) begin
                            o_byte_valid <= 1'b1;
                            o_byte       <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lc3_kbd_rx.sv
// LC-3 keyboard device: KBSR/KBDR registers, byte storage and interrupt on top of lc3_uart_rx.
// Define LC3_KBD_FIFO_EN for a 4-entry receive FIFO; otherwise a single holding register is used.
module lc3_kbd_rx
    import lc3_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [15:0] KBSR_ADDR    = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR    = KBDR_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    lc3_kbd_rx_if.slave bus,
    output logic        kbd_irq
);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       w_frame_err;

    logic        w_kbsr_rd;
    logic        w_kbdr_rd;
    logic        w_kbsr_wr;
    logic        w_consume;
    logic        w_ready;
    logic [7:0]  w_head;
    logic        w_push;
    logic        w_drop;
    logic        w_unused_wr;

    logic        r_ie;
    logic        r_ferr;
    logic        r_ovr;
    logic        r_irq;
    logic [15:0] r_rd_data;

    lc3_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (rx),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err)
    );

    assign w_kbsr_rd   = bus.rd_en && (bus.addr == KBSR_ADDR);
    assign w_kbdr_rd   = bus.rd_en && (bus.addr == KBDR_ADDR);
    assign w_kbsr_wr   = bus.wr_en && (bus.addr == KBSR_ADDR);
    assign w_consume   = w_kbdr_rd && w_ready;
    assign w_drop      = w_byte_valid && !w_push;
    assign w_unused_wr = ^{bus.wr_data[15], bus.wr_data[11:0]};

`ifdef LC3_KBD_FIFO_EN
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [COUNT_W-1:0] r_count;

    assign w_ready = (r_count != '0);
    // The slot just behind the read pointer still holds the most recently consumed byte
    assign w_head  = w_ready ? r_mem[r_rd_ptr] : r_mem[r_rd_ptr - PTR_W'(1)];
    assign w_push  = w_byte_valid && ((r_count != COUNT_W'(FIFO_DEPTH)) || w_consume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_byte;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_consume) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_consume})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [7:0] r_data;
    logic       r_ready;

    assign w_ready = r_ready;
    assign w_head  = r_data;
    assign w_push  = w_byte_valid && (!r_ready || w_consume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_data  <= w_byte;
                r_ready <= 1'b1;
            end else if (w_consume) begin
                r_ready <= 1'b0;
            end
        end
    end
`endif

    // Read data is captured from pre-write state, so a same-cycle KBSR write is not visible yet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ie      <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_irq     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_kbsr_wr) begin
                r_ie <= bus.wr_data[KBSR_IE];
            end
            r_ferr <= w_frame_err | (r_ferr & ~(w_kbsr_wr & bus.wr_data[KBSR_FERR]));
            r_ovr  <= w_drop      | (r_ovr  & ~(w_kbsr_wr & bus.wr_data[KBSR_OVR]));
            r_irq  <= w_ready & r_ie;
            if (w_kbsr_rd) begin
                r_rd_data <= kbsr_word(w_ready, r_ie, r_ferr, r_ovr);
            end else if (w_kbdr_rd) begin
                r_rd_data <= {8'h00, w_head};
            end else if (bus.rd_en) begin
                r_rd_data <= 16'h0000;
            end
        end
    end

    assign bus.rd_data = r_rd_data;
    assign kbd_irq     = r_irq;

endmodule

// File: tb/tb_lc3_kbd_rx.sv
// Self-checking bench for lc3_kbd_rx: directed scenarios plus randomized frames against a queue-based model.
module tb_lc3_kbd_rx;

    localparam int          CPB  = 16;
    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
`ifdef LC3_KBD_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic kbd_irq;

    always #5 clk = ~clk;

    lc3_kbd_rx_if bus ();

    lc3_kbd_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .bus     (bus),
        .kbd_irq (kbd_irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored bytes as a queue plus the three software-visible flags
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    logic       m_ie;
    logic       m_ferr;
    logic       m_ovr;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        m_q.delete();
        m_last = 8'h00;
        m_ie   = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    function automatic logic [15:0] m_kbsr();
        return {(m_q.size() != 0), m_ie, m_ferr, m_ovr, 12'h000};
    endfunction

    function automatic logic m_irq();
        return (m_q.size() != 0) && m_ie;
    endfunction

    task automatic m_accept(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic m_kbdr(output logic [15:0] v);
        if (m_q.size() != 0) m_last = m_q.pop_front();
        v = {8'h00, m_last};
    endtask

    task automatic m_write(input logic [15:0] w);
        m_ie = w[14];
        if (w[13]) m_ferr = 1'b0;
        if (w[12]) m_ovr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] w);
        bus.addr    = a;
        bus.wr_data = w;
        bus.wr_en   = 1'b1;
        tick(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_rw(input logic [15:0] a, input logic [15:0] w, output logic [15:0] d);
        bus.addr    = a;
        bus.wr_data = w;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        tick(1);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        d = bus.rd_data;
    endtask

    task automatic chk_kbsr(input string tag);
        logic [15:0] d;
        logic [15:0] exp;
        exp = m_kbsr();
        bus_read(KBSR, d);
        check(tag, d, exp);
    endtask

    task automatic chk_kbdr(input string tag);
        logic [15:0] d;
        logic [15:0] exp;
        m_kbdr(exp);
        bus_read(KBDR, d);
        check(tag, d, exp);
    endtask

    task automatic wr_kbsr(input logic [15:0] w);
        bus_write(KBSR, w);
        m_write(w);
    endtask

    task automatic chk_irq(input string tag);
        check(tag, {15'h0, kbd_irq}, {15'h0, m_irq()});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        send_frame(b, stop);
        m_accept(b, stop);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog no finish after 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] exp;
        logic [7:0]  b;
        logic        stop;
        int          wait_n;

        bus.addr    = '0;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        m_reset();

        tick(3);
        check("rst_rd_data", bus.rd_data, 16'h0000);
        check("rst_irq", {15'h0, kbd_irq}, 16'h0000);
        rst_n = 1'b1;
        tick(2);
        chk_kbsr("rst_kbsr");
        chk_kbdr("rst_kbdr");

        // Basic receive and consume
        send(8'h41, 1'b1);
        chk_kbsr("a_kbsr_ready");
        chk_kbdr("a_kbdr");
        chk_kbsr("a_kbsr_empty");
        bus_read(16'h1234, d);
        check("other_addr", d, 16'h0000);

        // Interrupt enable path
        wr_kbsr(16'h4000);
        send(8'h0D, 1'b1);
        chk_irq("irq_set");
        chk_kbsr("irq_kbsr");
        chk_kbdr("irq_kbdr");
        tick(2);
        chk_irq("irq_clr");
        wr_kbsr(16'h0000);

        // Framing error, then simultaneous read+write clearing it
        send(8'h55, 1'b0);
        chk_kbsr("ferr_kbsr");
        chk_kbdr("ferr_kbdr_empty");
        exp = m_kbsr();
        bus_rw(KBSR, 16'h2000, d);
        m_write(16'h2000);
        check("rw_pre_write", d, exp);
        chk_kbsr("rw_post_write");
        send(8'hAA, 1'b0);
        chk_kbsr("ferr2_kbsr");
        wr_kbsr(16'h2000);
        chk_kbsr("ferr2_clr");

        // Overrun: one more byte than storage holds
        for (int i = 0; i <= DEPTH; i++) begin
            send(8'h31 + 8'(i), 1'b1);
        end
        chk_kbsr("ovr_kbsr");
        for (int i = 0; i <= DEPTH; i++) begin
            chk_kbdr("ovr_kbdr");
        end
        chk_kbsr("ovr_empty");
        wr_kbsr(16'h1000);
        chk_kbsr("ovr_clr");

        // Short low glitch is ignored
        send(8'h5A, 1'b1);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * CPB);
        chk_kbsr("glitch_kbsr");
        chk_kbdr("glitch_kbdr");

        // Reset in the middle of a frame
        wr_kbsr(16'h4000);
        send(8'hC3, 1'b1);
        tick(2);
        chk_irq("pre_rst_irq");
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        rx = 1'b0;
        tick(CPB / 2);
        rx = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_data", bus.rd_data, 16'h0000);
        check("midrst_irq", {15'h0, kbd_irq}, 16'h0000);
        m_reset();
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk_kbsr("post_rst_kbsr");
        send(8'h7A, 1'b1);
        chk_kbsr("post_rst_ready");
        chk_kbdr("post_rst_kbdr");

        // KBDR read in the same cycle a new byte is accepted
        send(8'h10, 1'b1);
        fork
            send_frame(8'h20, 1'b1);
            begin
                wait_n = 0;
                while (dut.w_byte_valid !== 1'b1 && wait_n < 400) begin
                    tick(1);
                    wait_n++;
                end
                check("acc_seen", {15'h0, (wait_n < 400)}, 16'h0001);
                m_kbdr(exp);
                bus_read(KBDR, d);
                check("acc_rd_old", d, exp);
            end
        join
        m_accept(8'h20, 1'b1);
        chk_kbsr("acc_kbsr");
        chk_kbdr("acc_kbdr_new");
        chk_kbsr("acc_kbsr_empty");

        // Randomized frames and bus traffic
        for (int it = 0; it < 16; it++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
                rx = 1'b0;
                tick($urandom_range(1, 6));
                rx = 1'b1;
                tick(CPB);
            end
            send(b, stop);
            case ($urandom_range(0, 3))
                0: chk_kbsr("rnd_kbsr");
                1: chk_kbdr("rnd_kbdr");
                2: wr_kbsr(16'($urandom));
                default: begin
                    chk_kbdr("rnd_kbdr_a");
                    chk_kbdr("rnd_kbdr_b");
                end
            endcase
            tick(2);
            chk_irq("rnd_irq");
        end
        chk_kbsr("rnd_final_kbsr");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lc3_kbd_rx.md
LC3_KBD_RX -- requirements
Module: lc3_kbd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter KBSR_ADDR, default 16'hFE00, keyboard status register address.
REQ-003 SHALL have parameter KBDR_ADDR, default 16'hFE02, keyboard data register address.
REQ-004 clk  in  1  single system clock, the same clk that drives LC3; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rx  in  1  asynchronous UART serial input, 8N1, idles high.
REQ-007 addr  in  16  LC-3 memory-bus address.
REQ-008 rd_en  in  1  bus read strobe, one cycle.
REQ-009 wr_en  in  1  bus write strobe, one cycle.
REQ-010 wr_data  in  16  bus write data.
REQ-011 rd_data  out  16  registered read data.
REQ-012 kbd_irq  out  1  interrupt request to LC3.

Function
REQ-013 SHALL synchronise rx through two flops before any use.
REQ-014 Receive FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE->START on a synchronised high-to-low transition; the bit counter loads CLKS_PER_BIT/2.
REQ-016 START: at mid-bit, rx=0 -> DATA; rx=1 -> IDLE (false start, nothing stored).
REQ-017 DATA: SHALL sample 8 bits LSB first, each CLKS_PER_BIT cycles apart, then go to STOP.
REQ-018 STOP: at mid-bit, rx=1 -> byte accepted, go to IDLE; rx=0 -> byte discarded, KBSR[13] (frame_err) set, go to IDLE.
REQ-019 On an accepted byte, data SHALL be stored and KBSR[15] (ready) SHALL be set the following cycle.
REQ-020 If a byte is accepted while storage is full, it SHALL be dropped, KBSR[12] (overrun) SHALL be set, and stored data SHALL be kept.
REQ-021 A read SHALL return data on rd_data exactly 1 cycle after rd_en. KBSR reads {ready, ie, frame_err, overrun, 12'b0}. KBDR reads {8'b0, byte}. Any other addr returns 16'h0000.
REQ-022 A KBDR read SHALL consume the byte: ready clears when storage becomes empty. A KBDR read while empty returns the last byte and has no side effect.
REQ-023 A KBSR write SHALL load ie from wr_data[14]. It SHALL clear frame_err and overrun when wr_data[13] and wr_data[12] respectively are 1. ready is read-only.
REQ-024 If an accepted byte and a consuming KBDR read occur in the same cycle, the read SHALL return the old byte, the new byte SHALL be stored, and ready SHALL remain 1.
REQ-025 kbd_irq SHALL be the registered value of ready AND ie.
REQ-026 wr_en and rd_en asserted together SHALL both take effect: the read returns the pre-write value.

Reset
REQ-027 On rst_n low, asynchronously: FSM=IDLE, counters=0, sync flops=1, KBSR=16'h0000, storage empty, rd_data=16'h0000, kbd_irq=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame. After release, reception SHALL restart only on the next falling edge.

Configuration
REQ-029 Macro LC3_KBD_FIFO_EN defined: storage SHALL be a 4-entry FIFO; "full" means 4 entries; KBDR returns the oldest entry.
REQ-030 LC3_KBD_FIFO_EN undefined: storage SHALL be a single byte register; "full" means ready=1.

Structure
REQ-031 Shared package lc3_pkg SHALL hold the KBSR/KBDR address constants, the KBSR bit-index constants and the rx FSM state enum.
REQ-032 The serial receiver (REQ-013..018) SHALL be sub-module lc3_uart_rx, emitting a 1-cycle byte_valid, byte[7:0] and frame_err pulse. lc3_kbd_rx holds the registers, FIFO and bus logic.

Verification (bench: CLKS_PER_BIT=16, 10 ns clk)
REQ-033 Send 8'h41 -> KBSR reads 16'h8000; KBDR reads 16'h0041; KBSR then reads 16'h0000.
REQ-034 Write KBSR 16'h4000, then send 8'h0D -> kbd_irq=1 within 2 cycles of byte accept; read KBDR -> kbd_irq=0.
REQ-035 Send 8'h55 with stop bit=0 -> no byte stored; KBSR=16'h2000; write KBSR 16'h2000 -> KBSR=16'h0000.
REQ-036 Without FIFO send 8'h31, 8'h32 unread -> KBDR=16'h0031, KBSR[12]=1. With FIFO send 5 bytes -> first 4 read in order, overrun=1.
REQ-037 rx low pulse of 4 cycles -> no byte, KBSR unchanged. Assert rst_n mid-byte -> all registers 0, and the next full frame 8'h7A is received correctly.
REQ-038 KBDR read in the byte-accept cycle -> old byte returned, new byte readable next, ready stays 1.
